// File: rtl/gamma_pkg.sv
// ============================================================================
// gamma_pkg -- shared helpers for the piecewise-linear gamma stage:
//              identity-knot generator, FRAC_W/KNOTS helpers, LFSR constants.
// Rev 1.0
// ============================================================================
`default_nettype none

package gamma_pkg;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic int frac_w(input int in_w, input int seg_bits);
      return in_w - seg_bits;
   endfunction

   function automatic int knot_count(input int seg_bits);
      return (1 << seg_bits) + 1;
   endfunction

   function automatic logic [31:0] identity_knot(input int k, input int out_w,
                                                 input int seg_bits);
      int v;
      int m;
      v = k << (out_w - seg_bits);
      m = (1 << out_w) - 1;
      return (v > m) ? 32'(m) : 32'(v);
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

`default_nettype wire

// File: rtl/gamma_pwl_if.sv
// ============================================================================
// gamma_pwl_if -- pixel stream and knot-configuration bundle of gamma_pwl.
// Rev 1.0
// ============================================================================
`default_nettype none

interface gamma_pwl_if #(
   parameter int NUM_CH   = 3,
   parameter int IN_W     = 12,
   parameter int OUT_W    = 8,
   parameter int SEG_BITS = 5
);
   logic                      in_valid;
   logic                      frame_start;
   logic                      gamma_en;
   logic [NUM_CH*IN_W-1:0]    in_data;
   logic                      out_valid;
   logic [NUM_CH*OUT_W-1:0]   out_data;
   logic                      cfg_we;
   logic [SEG_BITS:0]         cfg_addr;
   logic [OUT_W-1:0]          cfg_wdata;
   logic                      cfg_commit;
   logic                      cfg_pending;
   logic                      cfg_err;
   logic                      cfg_err_clr;

   modport master (
      output in_valid, frame_start, gamma_en, in_data,
      output cfg_we, cfg_addr, cfg_wdata, cfg_commit, cfg_err_clr,
      input  out_valid, out_data, cfg_pending, cfg_err
   );

   modport slave (
      input  in_valid, frame_start, gamma_en, in_data,
      input  cfg_we, cfg_addr, cfg_wdata, cfg_commit, cfg_err_clr,
      output out_valid, out_data, cfg_pending, cfg_err
   );
endinterface

`default_nettype wire

// File: rtl/gamma_pwl_lane.sv
// ============================================================================
// gamma_pwl_lane -- one-channel 3-stage datapath: knot lookup, interpolate,
//                   clip, bypass select. GAMMA_DITHER_EN replaces the rounding
//                   constant with a per-channel LFSR.
// Rev 1.0
// ============================================================================
`default_nettype none

module gamma_pwl_lane
   import gamma_pkg::*;
#(
   parameter int IN_W     = 12,
   parameter int OUT_W    = 8,
   parameter int SEG_BITS = 5,
   parameter int CH       = 0
) (
   input  wire logic                                  clk,
   input  wire logic                                  rst,
   input  wire logic                                  in_valid,
   input  wire logic                                  gamma_en,
   input  wire logic [IN_W-1:0]                       x,
   input  wire logic [knot_count(SEG_BITS)*OUT_W-1:0] knots,
   output logic      [OUT_W-1:0]                      y
);
   localparam int FRAC_W = frac_w(IN_W, SEG_BITS);
   localparam int SH     = IN_W - OUT_W;
   localparam int PW     = OUT_W + FRAC_W + 2;
   localparam int YW     = OUT_W + 2;
   localparam logic signed [YW-1:0] Y_MAX   = YW'((1 << OUT_W) - 1);
   localparam logic        [IN_W:0] BYP_MAX = (IN_W+1)'((1 << OUT_W) - 1);

   logic [SEG_BITS-1:0] idx;
   logic [FRAC_W-1:0]   f;
   logic [OUT_W-1:0]    k0;
   logic [OUT_W-1:0]    k1;
   logic [IN_W:0]       byp_sum;
   logic [IN_W:0]       byp_shift;
   logic [OUT_W-1:0]    byp_val;
   logic [FRAC_W-1:0]   rnd;

   assign idx       = x[IN_W-1 -: SEG_BITS];
   assign f         = x[FRAC_W-1:0];
   assign k0        = knots[int'(idx)*OUT_W +: OUT_W];
   assign k1        = knots[(int'(idx)+1)*OUT_W +: OUT_W];
   assign byp_sum   = {1'b0, x} + (IN_W+1)'(1 << (SH - 1));
   assign byp_shift = byp_sum >> SH;
   assign byp_val   = (byp_shift > BYP_MAX) ? '1 : byp_shift[OUT_W-1:0];

`ifdef GAMMA_DITHER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= LFSR_SEED ^ 16'(CH);
      else if (in_valid)
         lfsr <= lfsr_next(lfsr);
   end

   assign rnd = lfsr[FRAC_W-1:0];
`else
   logic        unused_valid;
   logic [15:0] unused_ch;

   assign unused_valid = in_valid;
   assign unused_ch    = 16'(CH);
   assign rnd          = FRAC_W'(1 << (FRAC_W - 1));
`endif

   // S1: knot lookup plus everything the later stages need from this pixel
   logic [OUT_W-1:0]  s1_k0;
   logic [OUT_W-1:0]  s1_k1;
   logic [FRAC_W-1:0] s1_f;
   logic [FRAC_W-1:0] s1_rnd;
   logic              s1_ge;
   logic [OUT_W-1:0]  s1_byp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_k0  <= '0;
         s1_k1  <= '0;
         s1_f   <= '0;
         s1_rnd <= '0;
         s1_ge  <= 1'b0;
         s1_byp <= '0;
      end else begin
         s1_k0  <= k0;
         s1_k1  <= k1;
         s1_f   <= f;
         s1_rnd <= rnd;
         s1_ge  <= gamma_en;
         s1_byp <= byp_val;
      end
   end

   // S2: signed interpolation, floor shift so descending segments round consistently
   logic signed [OUT_W:0]  diff;
   logic signed [PW-1:0]   prod;
   logic signed [PW-1:0]   acc;
   logic signed [YW-1:0]   y_interp;

   assign diff     = $signed({1'b0, s1_k1}) - $signed({1'b0, s1_k0});
   assign prod     = PW'(diff) * PW'($signed({1'b0, s1_f}));
   assign acc      = prod + PW'($signed({1'b0, s1_rnd}));
   assign y_interp = $signed(YW'({2'b00, s1_k0})) + $signed(YW'(acc >>> FRAC_W));

   logic signed [YW-1:0] s2_y;
   logic                 s2_ge;
   logic [OUT_W-1:0]     s2_byp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_y   <= '0;
         s2_ge  <= 1'b0;
         s2_byp <= '0;
      end else begin
         s2_y   <= y_interp;
         s2_ge  <= s1_ge;
         s2_byp <= s1_byp;
      end
   end

   // S3: clip and select
   logic [OUT_W-1:0] y_clip;

   always_comb begin
      y_clip = s2_y[OUT_W-1:0];
      if (s2_y < 0)
         y_clip = '0;
      else if (s2_y > Y_MAX)
         y_clip = '1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         y <= '0;
      else
         y <= s2_ge ? y_clip : s2_byp;
   end

endmodule

`default_nettype wire

// File: rtl/gamma_pwl.sv
// ============================================================================
// gamma_pwl -- NUM_CH-channel piecewise-linear gamma with double-buffered knot
//              table swapped at frame start. Option macro: GAMMA_DITHER_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module gamma_pwl
   import gamma_pkg::*;
#(
   parameter int NUM_CH   = 3,
   parameter int IN_W     = 12,
   parameter int OUT_W    = 8,
   parameter int SEG_BITS = 5
) (
   input  wire logic    clk,
   input  wire logic    rst,
   gamma_pwl_if.slave   bus
);
   localparam int KNOTS = knot_count(SEG_BITS);
   localparam int AW    = SEG_BITS + 1;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PENDING = 1'b1;

   logic [0:0]       state;
   logic             bank_sel;
   logic             err;
   logic             swap;
   logic             sel_eff;
   logic             wr_hit;
   logic [OUT_W-1:0] bank0 [KNOTS];
   logic [OUT_W-1:0] bank1 [KNOTS];
   logic [KNOTS*OUT_W-1:0]  knots;
   logic [2:0]              vpipe;
   logic [NUM_CH*OUT_W-1:0] lane_out;

   // The swap cycle's own pixel must already see the new bank
   assign swap    = (state == ST_PENDING) && bus.frame_start;
   assign sel_eff = bank_sel ^ swap;
   assign wr_hit  = bus.cfg_we && (state == ST_IDLE) && (bus.cfg_addr < AW'(KNOTS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         bank_sel <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.cfg_commit)
                  state <= ST_PENDING;
            end
            ST_PENDING: begin
               if (bus.frame_start) begin
                  state    <= ST_IDLE;
                  bank_sel <= ~bank_sel;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err <= 1'b0;
      else if (bus.cfg_we && (state == ST_PENDING))
         err <= 1'b1;
      else if (bus.cfg_err_clr)
         err <= 1'b0;
   end

   // Writes always land in the bank not currently selected
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < KNOTS; k++) begin
            bank0[k] <= OUT_W'(identity_knot(k, OUT_W, SEG_BITS));
            bank1[k] <= OUT_W'(identity_knot(k, OUT_W, SEG_BITS));
         end
      end else if (wr_hit) begin
         if (bank_sel)
            bank0[bus.cfg_addr] <= bus.cfg_wdata;
         else
            bank1[bus.cfg_addr] <= bus.cfg_wdata;
      end
   end

   always_comb begin
      knots = '0;
      for (int k = 0; k < KNOTS; k++)
         knots[k*OUT_W +: OUT_W] = sel_eff ? bank1[k] : bank0[k];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vpipe <= '0;
      else
         vpipe <= {vpipe[1:0], bus.in_valid};
   end

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
         gamma_pwl_lane #(
            .IN_W     (IN_W),
            .OUT_W    (OUT_W),
            .SEG_BITS (SEG_BITS),
            .CH       (c)
         ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .in_valid (bus.in_valid),
            .gamma_en (bus.gamma_en),
            .x        (bus.in_data[c*IN_W +: IN_W]),
            .knots    (knots),
            .y        (lane_out[c*OUT_W +: OUT_W])
         );
      end
   endgenerate

   assign bus.out_valid   = vpipe[2];
   assign bus.out_data    = lane_out;
   assign bus.cfg_pending = (state == ST_PENDING);
   assign bus.cfg_err     = err;

endmodule

`default_nettype wire
